// File: rtl/trunc_pkg.sv
// Shared types and defaults for the truncated-product dot-product accumulator.
package trunc_pkg;
  localparam int ACC_W_DEF   = 16;
  localparam int MAX_LEN_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/trunc_dot_accum_sat_add.sv
// Saturating add of an 8-bit unsigned operand into an ACC_W accumulator value.
module sat_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [7:0]       b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W:0] wide;

  // ACC_W >= 8 is assumed so b always fits without truncation.
  assign wide = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
  assign ovf  = wide[ACC_W];
  assign sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
endmodule

// File: rtl/trunc_dot_accum.sv
// Accumulates truncated products per vector and presents a saturated sum, beat count and sticky saturation flag.
module trunc_dot_accum
  import trunc_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_sat
);
  localparam logic [7:0] MAX_CNT = MAX_LEN[7:0];

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             beat, take;
  logic [ACC_W-1:0] base_acc, add_sum;
  logic [7:0]       base_cnt, cnt_inc;
  logic             base_sat, add_ovf, vec_end;

  assign in_ready  = (state_q != ST_HOLD) || out_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign beat      = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // A beat accepted in HOLD starts a fresh vector, so it builds on zero.
  assign base_acc = (state_q == ST_HOLD) ? '0 : acc_q;
  assign base_cnt = (state_q == ST_HOLD) ? '0 : cnt_q;
  assign base_sat = (state_q == ST_HOLD) ? 1'b0 : sat_q;
  assign cnt_inc  = base_cnt + 8'd1;
  assign vec_end  = in_last || (cnt_inc == MAX_CNT);

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (base_acc),
    .b   (in_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (beat) begin
      acc_d   = add_sum;
      cnt_d   = cnt_inc;
      sat_d   = base_sat | add_ovf;
      state_d = vec_end ? ST_HOLD : ST_ACCUM;
    end else if (take) begin
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_sat   = sat_q;
endmodule

// File: tb/tb_trunc_dot_accum.sv
// Directed bench for trunc_dot_accum: default 16-bit instance plus an 8-bit instance for saturation.
module tb_trunc_dot_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
  logic [7:0]  in_prod, out_count;
  logic [15:0] out_sum;

  logic        in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_sat8;
  logic [7:0]  in_prod8, out_count8, out_sum8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trunc_dot_accum dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat)
  );

  trunc_dot_accum #(.ACC_W(8), .MAX_LEN(255)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_prod(in_prod8), .in_last(in_last8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum(out_sum8), .out_count(out_count8), .out_sat(out_sat8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] p, input logic l);
    in_valid = 1'b1; in_prod = p; in_last = l;
    tick();
  endtask

  task automatic outs(input string tag, input logic v, input logic [15:0] s,
                      input logic [7:0] c, input logic st);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sum"},   32'(out_sum),   32'(s));
    chk({tag, ".count"}, 32'(out_count), 32'(c));
    chk({tag, ".sat"},   32'(out_sat),   32'(st));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_prod = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_prod8 = 8'h00; in_last8 = 1'b0; out_ready8 = 1'b0;
    #1;
    outs("reset", 1'b0, 16'h0, 8'd0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Basic three-beat vector, consumer always ready
    out_ready = 1'b1;
    beat(8'h30, 1'b0);
    beat(8'h40, 1'b0);
    chk("basic.pre_valid", 32'(out_valid), 32'd0);
    beat(8'h10, 1'b1);
    in_valid = 1'b0;
    outs("basic", 1'b1, 16'h0080, 8'd3, 1'b0);
    tick();
    outs("basic.clear", 1'b0, 16'h0, 8'd0, 1'b0);

    // Backpressure: result held with in_ready low
    out_ready = 1'b0;
    beat(8'h7F, 1'b1);
    in_valid = 1'b1; in_prod = 8'hAA; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      outs("hold", 1'b1, 16'h007F, 8'd1, 1'b0);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("hold.release_ready", 32'(in_ready), 32'd1);
    tick();
    outs("hold.clear", 1'b0, 16'h0, 8'd0, 1'b0);

    // Take the result and start a new vector in the same cycle
    out_ready = 1'b0;
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b1);
    in_valid = 1'b0;
    outs("b2b.old", 1'b1, 16'h0005, 8'd2, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_prod = 8'h05; in_last = 1'b0;
    #1;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    outs("b2b.new", 1'b0, 16'h0005, 8'd1, 1'b0);
    beat(8'h01, 1'b1);
    in_valid = 1'b0;
    outs("b2b.end", 1'b1, 16'h0006, 8'd2, 1'b0);
    tick();

    // Reset mid-vector drops the partial sum
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    outs("rstmid", 1'b0, 16'h0, 8'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid.after", 32'(out_valid), 32'd0);
    beat(8'h01, 1'b1);
    in_valid = 1'b0;
    outs("rstmid.next", 1'b1, 16'h0001, 8'd1, 1'b0);
    tick();

    // Idle inputs with garbage data must not disturb a partial vector
    beat(8'h09, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_prod = 8'(i * 37 + 5);
      in_last = i[0];
      tick();
    end
    outs("noise", 1'b0, 16'h0009, 8'd1, 1'b0);
    beat(8'h01, 1'b1);
    in_valid = 1'b0;
    outs("noise.end", 1'b1, 16'h000A, 8'd2, 1'b0);
    tick();

    // Zero product still counts
    beat(8'h00, 1'b0);
    beat(8'h04, 1'b1);
    in_valid = 1'b0;
    outs("zero", 1'b1, 16'h0004, 8'd2, 1'b0);
    tick();

    // 8-bit accumulator: saturation and forced end at MAX_LEN
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; in_prod8 = 8'hFF; in_last8 = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    chk("max.pre_valid", 32'(out_valid8), 32'd0);
    chk("max.pre_count", 32'(out_count8), 32'd254);
    tick();
    in_valid8 = 1'b0;
    chk("max.valid", 32'(out_valid8), 32'd1);
    chk("max.sum",   32'(out_sum8),   32'h00FF);
    chk("max.count", 32'(out_count8), 32'd255);
    chk("max.sat",   32'(out_sat8),   32'd1);
    tick();
    chk("max.clear_sat",   32'(out_sat8),   32'd0);
    chk("max.clear_valid", 32'(out_valid8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
